// File: rtl/pagerank_stream_scheduler.sv
// pagerank_stream_scheduler
// Drives one PageRank iteration through the shared accumulate/damp/delta datapath.
// Every partition engine is granted once per iteration, in round-robin order, for a
// fixed-length burst. The stream is framed with stream_start/stream_done, and the
// block then waits for the datapath to call for another iteration or report convergence.
module pagerank_stream_scheduler #(
    parameter int NUM_PARTITIONS = 4,
    parameter int BURST_LEN      = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_PARTITIONS-1:0]         part_req,
    input  logic [NUM_PARTITIONS-1:0]         part_beat_valid,
    output logic [NUM_PARTITIONS-1:0]         part_grant,
    output logic [$clog2(NUM_PARTITIONS)-1:0] stream_sel,
    output logic                              stream_valid,
    output logic                              stream_start,
    output logic                              stream_done,
    input  logic                              next_iteration,
    input  logic                              pagerank_complete,
    output logic [NUM_PARTITIONS-1:0]         served_mask,
    output logic [31:0]                       iteration_count,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_err
);

    localparam int SEL_W  = $clog2(NUM_PARTITIONS);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_BURST,
        S_WAIT_DP,
        S_FINISHED
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [SEL_W-1:0]          rr_ptr;
    logic [SEL_W-1:0]          rr_after;
    logic [SEL_W-1:0]          pick_idx;
    logic [SEL_W-1:0]          cand;
    logic                      pick_found;
    logic [NUM_PARTITIONS-1:0] eligible;
    logic                      all_served;
    logic                      start_ok;
    logic                      beat_accept;
    logic                      last_beat;
    logic                      idle_abort;
    logic                      first_beat;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [IDLE_W-1:0]         idle_cnt;

    assign eligible    = part_req & ~served_mask;
    assign all_served  = &served_mask;
    assign start_ok    = start && (state == S_IDLE || state == S_FINISHED);
    assign beat_accept = (state == S_BURST) && part_beat_valid[stream_sel];
    assign last_beat   = beat_accept && (beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign idle_abort  = (state == S_BURST) && !part_beat_valid[stream_sel]
                         && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign rr_after    = (stream_sel == SEL_W'(NUM_PARTITIONS - 1)) ? '0 : stream_sel + SEL_W'(1);

    // Round-robin pick: first eligible engine at or after the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_PARTITIONS; k++) begin
            cand = SEL_W'((int'(rr_ptr) + k) % NUM_PARTITIONS);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: completion has priority over next_iteration while waiting on the datapath.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_FINISHED: begin
                if (start) state_next = S_ARB;
            end
            S_ARB: begin
                if (all_served)      state_next = S_WAIT_DP;
                else if (pick_found) state_next = S_BURST;
            end
            S_BURST: begin
                if (last_beat || idle_abort) state_next = S_ARB;
            end
            S_WAIT_DP: begin
                if (pagerank_complete)   state_next = S_FINISHED;
                else if (next_iteration) state_next = S_ARB;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Stream framing and status outputs decoded from the current state and beat.
    always_comb begin
        stream_valid = beat_accept;
        stream_start = beat_accept && first_beat;
        stream_done  = (state == S_ARB) && all_served;
        busy         = (state != S_IDLE) && (state != S_FINISHED);
        done         = (state == S_FINISHED);
    end

    // Grant, counters, served bookkeeping and sticky error; the grant drops the cycle after a burst ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            part_grant      <= '0;
            stream_sel      <= '0;
            rr_ptr          <= '0;
            served_mask     <= '0;
            iteration_count <= '0;
            timeout_err     <= 1'b0;
            first_beat      <= 1'b0;
            beat_cnt        <= '0;
            idle_cnt        <= '0;
        end else begin
            if (start_ok) begin
                served_mask     <= '0;
                iteration_count <= '0;
                timeout_err     <= 1'b0;
                first_beat      <= 1'b1;
            end
            case (state)
                S_ARB: begin
                    if (!all_served && pick_found) begin
                        part_grant <= NUM_PARTITIONS'(1) << pick_idx;
                        stream_sel <= pick_idx;
                        beat_cnt   <= '0;
                        idle_cnt   <= '0;
                    end
                end
                S_BURST: begin
                    if (beat_accept) begin
                        first_beat <= 1'b0;
                        idle_cnt   <= '0;
                        if (last_beat) begin
                            served_mask[stream_sel] <= 1'b1;
                            rr_ptr                  <= rr_after;
                            part_grant              <= '0;
                            beat_cnt                <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (idle_abort) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= rr_after;
                        part_grant  <= '0;
                        beat_cnt    <= '0;
                        idle_cnt    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                S_WAIT_DP: begin
                    if (!pagerank_complete && next_iteration) begin
                        served_mask     <= '0;
                        iteration_count <= iteration_count + 32'd1;
                        first_beat      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pagerank_stream_scheduler.sv
// tb_pagerank_stream_scheduler
// Directed bench for the PageRank stream scheduler (4 engines, 4-beat bursts, 8-cycle timeout).
// A transaction-level model tracks the iteration and compares every DUT output on each
// falling edge. Literal expectations on grant order, burst lengths and framing pin the model.
module tb_pagerank_stream_scheduler;

    localparam int NP = 4;
    localparam int BL = 4;
    localparam int TO = 8;

    localparam int P_IDLE  = 0;
    localparam int P_ARB   = 1;
    localparam int P_BURST = 2;
    localparam int P_WAIT  = 3;
    localparam int P_FIN   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  part_req = 4'h0;
    logic [3:0]  part_beat_valid = 4'h0;
    logic        next_iteration = 1'b0;
    logic        pagerank_complete = 1'b0;
    logic [3:0]  part_grant;
    logic [1:0]  stream_sel;
    logic        stream_valid;
    logic        stream_start;
    logic        stream_done;
    logic [3:0]  served_mask;
    logic [31:0] iteration_count;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    pagerank_stream_scheduler #(
        .NUM_PARTITIONS(NP),
        .BURST_LEN     (BL),
        .TIMEOUT       (TO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .part_req         (part_req),
        .part_beat_valid  (part_beat_valid),
        .part_grant       (part_grant),
        .stream_sel       (stream_sel),
        .stream_valid     (stream_valid),
        .stream_start     (stream_start),
        .stream_done      (stream_done),
        .next_iteration   (next_iteration),
        .pagerank_complete(pagerank_complete),
        .served_mask      (served_mask),
        .iteration_count  (iteration_count),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err)
    );

    always #5 clock = ~clock;

    // Model of the iteration: phase, served engines, fairness pointer, current owner and its counts.
    int          m_phase = P_IDLE;
    bit [3:0]    m_served = 4'h0;
    int          m_rr = 0;
    int          m_owner = 0;
    bit [1:0]    m_sel = 2'd0;
    int          m_beats = 0;
    int          m_idle = 0;
    bit          m_first = 1'b0;
    bit          m_terr = 1'b0;
    bit [31:0]   m_iter = 32'd0;

    // Monitor bookkeeping used by the literal checks.
    logic [3:0]  prev_grant = 4'h0;
    int          cur_beats = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    logic [1:0]  grant_log[$];
    int          beat_log[$];

    logic [3:0]  e_grant;
    logic        e_valid;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of the iteration rules, applied to the inputs seen at this rising edge.
    task automatic modelStep();
        bit beat;
        int pick;
        int e;
        beat = (m_phase == P_BURST) && part_beat_valid[m_owner];
        case (m_phase)
            P_IDLE, P_FIN: begin
                if (start) begin
                    m_phase  = P_ARB;
                    m_served = 4'h0;
                    m_iter   = 32'd0;
                    m_terr   = 1'b0;
                    m_first  = 1'b1;
                end
            end
            P_ARB: begin
                if (m_served == 4'hF) begin
                    m_phase = P_WAIT;
                end else begin
                    pick = -1;
                    for (int k = 0; k < NP; k++) begin
                        e = (m_rr + k) % NP;
                        if (pick < 0 && part_req[e] && !m_served[e]) pick = e;
                    end
                    if (pick >= 0) begin
                        m_owner = pick;
                        m_sel   = 2'(pick);
                        m_beats = 0;
                        m_idle  = 0;
                        m_phase = P_BURST;
                    end
                end
            end
            P_BURST: begin
                if (beat) begin
                    m_first = 1'b0;
                    m_idle  = 0;
                    m_beats++;
                    if (m_beats == BL) begin
                        m_served[m_owner] = 1'b1;
                        m_rr    = (m_owner + 1) % NP;
                        m_phase = P_ARB;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_terr  = 1'b1;
                        m_rr    = (m_owner + 1) % NP;
                        m_phase = P_ARB;
                    end
                end
            end
            P_WAIT: begin
                if (pagerank_complete) begin
                    m_phase = P_FIN;
                end else if (next_iteration) begin
                    m_served = 4'h0;
                    m_iter   = m_iter + 32'd1;
                    m_first  = 1'b1;
                    m_phase  = P_ARB;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    // Advance the model on each rising edge; reset returns it to its power-on picture at once.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase  = P_IDLE;
            m_served = 4'h0;
            m_rr     = 0;
            m_owner  = 0;
            m_sel    = 2'd0;
            m_beats  = 0;
            m_idle   = 0;
            m_first  = 1'b0;
            m_terr   = 1'b0;
            m_iter   = 32'd0;
        end else begin
            modelStep();
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        if (check_en) begin
            e_grant = (m_phase == P_BURST) ? 4'(1 << m_owner) : 4'h0;
            e_valid = (m_phase == P_BURST) && part_beat_valid[m_owner];
            checkOutput("part_grant", part_grant, e_grant);
            checkOutput("stream_sel", stream_sel, m_sel);
            checkOutput("stream_valid", stream_valid, e_valid);
            checkOutput("stream_start", stream_start, e_valid && m_first);
            checkOutput("stream_done", stream_done, (m_phase == P_ARB) && (m_served == 4'hF));
            checkOutput("served_mask", served_mask, m_served);
            checkOutput("iteration_count", iteration_count, m_iter);
            checkOutput("busy", busy, (m_phase != P_IDLE) && (m_phase != P_FIN));
            checkOutput("done", done, m_phase == P_FIN);
            checkOutput("timeout_err", timeout_err, m_terr);
        end
    end

    // Record grant order, beats per tenure and framing pulses as seen on the DUT pins.
    always @(negedge clock) begin
        if (stream_start) start_cnt++;
        if (stream_done) done_cnt++;
        if (part_grant != 4'h0 && prev_grant == 4'h0) grant_log.push_back(stream_sel);
        if (part_grant != 4'h0 && stream_valid) cur_beats++;
        if (part_grant == 4'h0 && prev_grant != 4'h0) begin
            beat_log.push_back(cur_beats);
            cur_beats = 0;
        end
        prev_grant = part_grant;
    end

    function automatic logic [31:0] packGrants();
        logic [31:0] v;
        v = 32'(grant_log.size()) << 16;
        for (int i = 0; i < grant_log.size() && i < 8; i++) v = v | (32'(grant_log[i]) << (2 * (grant_log.size() - 1 - i)));
        return v;
    endfunction

    function automatic logic [31:0] packBeats();
        logic [31:0] v;
        v = 32'(beat_log.size()) << 16;
        for (int i = 0; i < beat_log.size() && i < 4; i++) v = v | (32'(beat_log[i] & 15) << (4 * (beat_log.size() - 1 - i)));
        return v;
    endfunction

    function automatic int lastBeats();
        if (beat_log.size() == 0) return -1;
        return beat_log[beat_log.size() - 1];
    endfunction

    task automatic clearLogs();
        grant_log.delete();
        beat_log.delete();
        start_cnt = 0;
        done_cnt  = 0;
    endtask

    task automatic applyStimulus(input bit st, input logic [3:0] rq, input logic [3:0] bv, input bit nx, input bit cp);
        @(posedge clock);
        #1;
        start             = st;
        part_req          = rq;
        part_beat_valid   = bv;
        next_iteration    = nx;
        pagerank_complete = cp;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic waitGrant(input logic [3:0] mask, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            settle();
            if (part_grant == mask) break;
        end
        checkOutput(name, part_grant, mask);
    endtask

    task automatic waitDone(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            settle();
            if (stream_done) break;
        end
        checkOutput(name, stream_done, 1);
    endtask

    // Hard stop in case a wait ever escapes its own budget.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        #1 reset = 1'b1;
        check_en = 1'b1;
        #11 reset = 1'b0;
        settle();
        checkOutput("rst_grant", part_grant, 4'h0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_iter", iteration_count, 0);

        // Full iteration with every engine ready and always valid.
        $display("[TB] all engines streaming");
        clearLogs();
        applyStimulus(1, 4'hF, 4'hF, 0, 0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        waitDone(60, "t2_done_seen");
        settle();
        checkOutput("t2_order", packGrants(), 32'h0004_001B);
        checkOutput("t2_beats", packBeats(), 32'h0004_4444);
        checkOutput("t2_start_cnt", start_cnt, 1);
        checkOutput("t2_done_cnt", done_cnt, 1);
        checkOutput("t2_served", served_mask, 4'hF);
        checkOutput("t2_wait_busy", busy, 1);

        // Next iteration with only engine 2 ready, others join later.
        $display("[TB] late requesters and pointer wrap");
        clearLogs();
        applyStimulus(0, 4'b0100, 4'hF, 1, 0);
        applyStimulus(0, 4'b0100, 4'hF, 0, 0);
        settle();
        checkOutput("t4_iter_inc", iteration_count, 1);
        checkOutput("t4_served_clr", served_mask, 4'h0);
        repeat (10) @(posedge clock);
        settle();
        checkOutput("t3_served_e2", served_mask, 4'b0100);
        checkOutput("t3_arb_idle", part_grant, 4'h0);
        applyStimulus(0, 4'b1011, 4'hF, 0, 0);
        waitDone(60, "t3_done_seen");
        settle();
        checkOutput("t3_order", packGrants(), 32'h0004_00B1);
        checkOutput("t3_served", served_mask, 4'hF);
        checkOutput("t4_new_start", start_cnt, 1);

        // Converged verdict wins over a simultaneous next_iteration.
        applyStimulus(0, 4'hF, 4'hF, 1, 1);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        settle();
        checkOutput("t4_done", done, 1);
        checkOutput("t4_not_busy", busy, 0);
        checkOutput("t4_iter_hold", iteration_count, 1);

        // Non-granted valid is ignored; start during a burst is ignored.
        $display("[TB] foreign valid and stray start");
        clearLogs();
        applyStimulus(1, 4'b0001, 4'b1000, 0, 0);
        applyStimulus(0, 4'b0001, 4'b1000, 0, 0);
        waitGrant(4'b0001, 20, "t6_grant");
        checkOutput("t6_no_valid", stream_valid, 0);
        checkOutput("t6_iter_clr", iteration_count, 0);
        applyStimulus(1, 4'b0001, 4'b1000, 0, 0);
        applyStimulus(0, 4'b0001, 4'b0001, 0, 0);
        settle();
        checkOutput("t6_start_ignored", part_grant, 4'b0001);
        checkOutput("t6_own_valid", stream_valid, 1);
        repeat (8) @(posedge clock);

        // Engine 1 stalls after two beats and is aborted by the timeout.
        $display("[TB] burst timeout");
        applyStimulus(0, 4'b0010, 4'b0000, 0, 0);
        waitGrant(4'b0010, 20, "t5_grant");
        applyStimulus(0, 4'b0010, 4'b0010, 0, 0);
        applyStimulus(0, 4'b0010, 4'b0010, 0, 0);
        applyStimulus(0, 4'b0000, 4'b0000, 0, 0);
        repeat (12) @(posedge clock);
        settle();
        checkOutput("t5_terr", timeout_err, 1);
        checkOutput("t5_grant_drop", part_grant, 4'h0);
        checkOutput("t5_not_served", served_mask, 4'b0001);
        checkOutput("t5_partial", lastBeats(), 2);
        applyStimulus(0, 4'b0010, 4'b0010, 0, 0);
        waitGrant(4'b0010, 20, "t5_regrant");
        repeat (8) @(posedge clock);
        settle();
        checkOutput("t5_served", served_mask, 4'b0011);
        checkOutput("t5_full", lastBeats(), 4);
        checkOutput("t5_terr_sticky", timeout_err, 1);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        waitDone(60, "t5_done_seen");
        settle();
        checkOutput("t5_terr_keep", timeout_err, 1);
        checkOutput("t6_start_cnt", start_cnt, 1);
        applyStimulus(0, 4'hF, 4'hF, 0, 1);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        settle();
        checkOutput("t5_finished", done, 1);
        applyStimulus(1, 4'hF, 4'hF, 0, 0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        settle();
        checkOutput("t5_terr_cleared", timeout_err, 0);

        // Asynchronous reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        waitGrant(4'b0010, 30, "t1_second_grant");
        #2 reset = 1'b1;
        #1;
        checkOutput("t1_grant", part_grant, 4'h0);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_served", served_mask, 4'h0);
        checkOutput("t1_valid", stream_valid, 0);
        applyStimulus(0, 4'hF, 4'hF, 0, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        repeat (5) @(posedge clock);
        settle();
        checkOutput("t1_stay_grant", part_grant, 4'h0);
        checkOutput("t1_stay_busy", busy, 0);
        checkOutput("t1_stay_done", done, 0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
